driver_controller: RTL and testbench
====================================

DRIVER_CONTROLLER -- requirements
Module: driver_controller

Interface
REQ-001 SHALL have parameter NB_DRIVERS, default 30, number of driver serial lanes.
REQ-002 SHALL have parameter POKER_MODE, default 9, bit-planes per column.
REQ-003 SHALL have parameter MULTIPLEXING, default 8, columns per slice.
REQ-004 SHALL have parameter WORD_BITS, default 48, bits per bit-plane word (16 LEDs x 3 colours).
REQ-005 SHALL have parameter SYNC_TO_DATA, default 79, cycles from the sync cycle to the first valid data cycle.
REQ-006 SHALL have ports:
- clk_33, in, 1: system clock.
- nrst, in, 1: synchronous, active-low reset.
- data, in, NB_DRIVERS: one serial bit per driver per cycle, from the framebuffer.
- sync, in, 1: one-cycle pulse marking the start of a slice.
- drv_sin, out, NB_DRIVERS: registered serial data to drivers.
- drv_sclk_en, out, 1: high when drv_sin is valid for one SCLK edge; the top level forwards SCLK through a DDR cell.
- drv_lat, out, 1: driver latch line.
- col_sel, out, MULTIPLEXING: one-hot column transistor select.
- busy, out, 1: high while a slice is in progress.
- err, out, 1: one-cycle pulse on a protocol error.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, STREAM.
REQ-008 IDLE: sync=1 -> WAIT; the delay counter loads SYNC_TO_DATA-1.
REQ-009 WAIT: the delay counter decrements each cycle; at 0 the next cycle is STREAM, and that cycle carries data bit 0.
REQ-010 STREAM: every cycle captures data into drv_sin one cycle later (latency 1) with drv_sclk_en=1.
REQ-011 STREAM SHALL hold counters:
- bit_cnt 0..WORD_BITS-1.
- plane_cnt POKER_MODE-1 down to 0.
- col_cnt 0..MULTIPLEXING-1.
bit_cnt wraps and decrements plane_cnt; plane_cnt wraps to POKER_MODE-1 and increments col_cnt.
REQ-012 drv_lat SHALL be high together with drv_sin for the last 1 bit of a word when plane_cnt!=0 (WRTGS).
REQ-013 drv_lat SHALL be high together with drv_sin for the last 3 bits of a word when plane_cnt==0 (LATGS).
REQ-014 col_sel SHALL shift to the next one-hot position on the cycle after the last LATGS bit leaves drv_sin; it wraps from bit MULTIPLEXING-1 to bit 0.
REQ-015 After the last bit of column MULTIPLEXING-1, the FSM SHALL return to IDLE. The slice is POKER_MODE*WORD_BITS*MULTIPLEXING = 3456 stream cycles.
REQ-016 sync during WAIT or STREAM SHALL:
- pulse err;
- discard the partial word;
- force drv_lat=0 and drv_sclk_en=0 on the next cycle;
- reset all counters;
- reload the delay counter and enter WAIT.
REQ-017 sync on the same cycle as the final stream bit SHALL be accepted as a new slice without err.
REQ-018 busy SHALL be 1 in WAIT and STREAM, 0 in IDLE.
REQ-019 Outside STREAM, drv_sin=0, drv_sclk_en=0, drv_lat=0.
REQ-020 col_sel SHALL retain its value across IDLE/WAIT; a new slice starts from the current column, with no forced realignment.
REQ-021 All counters SHALL be sized with $clog2 of their parameter; width overflow SHALL be impossible for the default parameters.

Reset
REQ-022 On nrst=0 at a clk_33 edge:
- state=IDLE, all counters=0, plane_cnt=POKER_MODE-1;
- drv_sin=0, drv_sclk_en=0, drv_lat=0, busy=0, err=0;
- col_sel=1 (column 0).
REQ-023 Reset asserted mid-stream SHALL take effect on the same edge, and the outputs SHALL never emit a partial latch pulse afterwards.

Structure
REQ-024 MULTIPLEXING, POKER_MODE, WORD_BITS, LED_PER_DRIVER (16) and the FSM state enum SHALL be placed in shared package spirose_pkg; the framebuffer SHALL use the same constants.
REQ-025 The latch-command decoder (bit_cnt, plane_cnt -> drv_lat) SHALL be a sub-module named lat_gen.
REQ-026 The serial datapath SHALL stay inline in driver_controller.

Verification
REQ-027 Nominal slice: sync at cycle 0, data=alternating 0x2AAAAAAA/0x15555555 -> first drv_sclk_en at cycle 80; 3456 enabled cycles; busy falls at cycle 3536.
REQ-028 Latch pattern: count drv_lat cycles per column -> 8 planes x 1 + 1 plane x 3 = 11 cycles; 3-cycle pulses at word-relative bits 45..47 of plane 0 only.
REQ-029 Column stepping: full slice from reset -> col_sel sequence 0x01, 0x02, ..., 0x80, then back to 0x01 after the slice end.
REQ-030 Early sync at stream cycle 1000 -> err=1 for exactly one cycle; no drv_lat between cycles 1000 and 1080; counters restart; next first data at sync+80.
REQ-031 Back-to-back sync on the final stream bit -> err=0; busy stays 1; second slice data begins 80 cycles later.
REQ-032 nrst=0 for 1 cycle at stream cycle 500 -> all outputs 0 and col_sel=0x01 next cycle; subsequent sync produces a nominal slice.

Source files
------------

// File: rtl/spirose_pkg.sv
// Shared constants and types for the LED driver chain and the framebuffer.
// The framebuffer imports the same geometry so both sides agree on slice layout.
package spirose_pkg;

  localparam int unsigned LED_PER_DRIVER = 16;
  localparam int unsigned COLOURS        = 3;
  localparam int unsigned WORD_BITS      = LED_PER_DRIVER * COLOURS;
  localparam int unsigned POKER_MODE     = 9;
  localparam int unsigned MULTIPLEXING   = 8;

  // Latch-line widths at the end of a word: write-GS vs latch-GS command
  localparam int unsigned WRTGS_BITS = 1;
  localparam int unsigned LATGS_BITS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } drv_state_t;

  // Counter width for 0..n-1, never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/driver_controller_lat_gen.sv
// Latch-command decoder: drives the latch line for the tail bits of each word.
// One bit (WRTGS) on ordinary planes, three bits (LATGS) on the final plane.
module lat_gen #(
  parameter int unsigned WORD_BITS  = spirose_pkg::WORD_BITS,
  parameter int unsigned POKER_MODE = spirose_pkg::POKER_MODE,
  parameter int unsigned BIT_W      = spirose_pkg::clog2_min1(WORD_BITS),
  parameter int unsigned PLANE_W    = spirose_pkg::clog2_min1(POKER_MODE)
) (
  input  logic [BIT_W-1:0]   bit_cnt,
  input  logic [PLANE_W-1:0] plane_cnt,
  output logic               lat_c
);
  import spirose_pkg::*;

  localparam logic [BIT_W-1:0] WRTGS_FIRST = BIT_W'(WORD_BITS - WRTGS_BITS);
  localparam logic [BIT_W-1:0] LATGS_FIRST = BIT_W'(WORD_BITS - LATGS_BITS);

  always_comb begin
    lat_c = 1'b0;
    if (plane_cnt == '0) begin
      lat_c = (bit_cnt >= LATGS_FIRST);
    end else begin
      lat_c = (bit_cnt >= WRTGS_FIRST);
    end
  end

endmodule

// File: rtl/driver_controller.sv
// Streams one slice of framebuffer bits to the LED driver chains, generating
// latch commands and stepping the column transistors between columns.
module driver_controller #(
  parameter int unsigned NB_DRIVERS   = 30,
  parameter int unsigned POKER_MODE   = spirose_pkg::POKER_MODE,
  parameter int unsigned MULTIPLEXING = spirose_pkg::MULTIPLEXING,
  parameter int unsigned WORD_BITS    = spirose_pkg::WORD_BITS,
  parameter int unsigned SYNC_TO_DATA = 79
) (
  input  logic                    clk_33,
  input  logic                    nrst,
  input  logic [NB_DRIVERS-1:0]   data,
  input  logic                    sync,
  output logic [NB_DRIVERS-1:0]   drv_sin,
  output logic                    drv_sclk_en,
  output logic                    drv_lat,
  output logic [MULTIPLEXING-1:0] col_sel,
  output logic                    busy,
  output logic                    err
);
  import spirose_pkg::*;

  localparam int unsigned BIT_W   = clog2_min1(WORD_BITS);
  localparam int unsigned PLANE_W = clog2_min1(POKER_MODE);
  localparam int unsigned COL_W   = clog2_min1(MULTIPLEXING);
  localparam int unsigned DLY_W   = clog2_min1(SYNC_TO_DATA);

  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(WORD_BITS - 1);
  localparam logic [PLANE_W-1:0] PLANE_TOP = PLANE_W'(POKER_MODE - 1);
  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(MULTIPLEXING - 1);
  localparam logic [DLY_W-1:0]   DLY_LOAD  = DLY_W'(SYNC_TO_DATA - 1);

  drv_state_t state, next_state;

  logic [BIT_W-1:0]   bit_cnt;
  logic [PLANE_W-1:0] plane_cnt;
  logic [COL_W-1:0]   col_cnt;
  logic [DLY_W-1:0]   dly_cnt;
  logic               col_done;

  logic start_c, abort_c, capture_c;
  logic word_end_c, plane_end_c, slice_end_c;
  logic lat_c;

  lat_gen #(
    .WORD_BITS  (WORD_BITS),
    .POKER_MODE (POKER_MODE),
    .BIT_W      (BIT_W),
    .PLANE_W    (PLANE_W)
  ) u_lat_gen (
    .bit_cnt   (bit_cnt),
    .plane_cnt (plane_cnt),
    .lat_c     (lat_c)
  );

  // State register
  always_ff @(posedge clk_33) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and per-cycle control; a sync on the final bit chains slices
  always_comb begin
    next_state  = state;
    start_c     = 1'b0;
    abort_c     = 1'b0;
    capture_c   = 1'b0;
    word_end_c  = (bit_cnt == BIT_LAST);
    plane_end_c = word_end_c && (plane_cnt == '0);
    slice_end_c = plane_end_c && (col_cnt == COL_LAST);
    unique case (state)
      IDLE: begin
        if (sync) begin
          next_state = WAIT;
          start_c    = 1'b1;
        end
      end
      WAIT: begin
        if (sync) begin
          abort_c = 1'b1;
          start_c = 1'b1;
        end else if (dly_cnt <= DLY_W'(1)) begin
          next_state = STREAM;
        end
      end
      STREAM: begin
        if (sync && !slice_end_c) begin
          next_state = WAIT;
          abort_c    = 1'b1;
          start_c    = 1'b1;
        end else begin
          capture_c = 1'b1;
          if (slice_end_c) begin
            next_state = sync ? WAIT : IDLE;
            start_c    = sync;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Delay, bit, plane and column counters
  always_ff @(posedge clk_33) begin
    if (!nrst) begin
      dly_cnt   <= '0;
      bit_cnt   <= '0;
      plane_cnt <= PLANE_TOP;
      col_cnt   <= '0;
    end else begin
      if (start_c) begin
        dly_cnt <= DLY_LOAD;
      end else if (state == WAIT && dly_cnt != '0) begin
        dly_cnt <= dly_cnt - DLY_W'(1);
      end

      if (abort_c) begin
        bit_cnt   <= '0;
        plane_cnt <= PLANE_TOP;
        col_cnt   <= '0;
      end else if (capture_c) begin
        if (word_end_c) begin
          bit_cnt <= '0;
          if (plane_cnt == '0) begin
            plane_cnt <= PLANE_TOP;
            col_cnt   <= (col_cnt == COL_LAST) ? '0 : col_cnt + COL_W'(1);
          end else begin
            plane_cnt <= plane_cnt - PLANE_W'(1);
          end
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

  // Serial datapath and column select; col_sel steps once the LATGS tail has left drv_sin
  always_ff @(posedge clk_33) begin
    if (!nrst) begin
      drv_sin     <= '0;
      drv_sclk_en <= 1'b0;
      drv_lat     <= 1'b0;
      col_done    <= 1'b0;
      col_sel     <= MULTIPLEXING'(1);
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      drv_sin     <= capture_c ? data : '0;
      drv_sclk_en <= capture_c;
      drv_lat     <= capture_c && lat_c;
      col_done    <= capture_c && plane_end_c;
      busy        <= (next_state != IDLE) || (state == STREAM);
      err         <= abort_c;
      if (col_done) begin
        col_sel <= (col_sel << 1) | (col_sel >> (MULTIPLEXING - 1));
      end
    end
  end

endmodule

// File: tb/tb_driver_controller.sv
// Directed bench for driver_controller: nominal slice, early sync,
// back-to-back slices and mid-stream reset, checked against a stream model.
module tb_driver_controller;

  localparam int unsigned NB = 30;
  localparam int SLICE = 3456;
  localparam int COL_BITS = 432;
  localparam logic [NB-1:0] PAT_A = 30'h2AAAAAAA;
  localparam logic [NB-1:0] PAT_B = 30'h15555555;

  logic          clk_33 = 1'b0;
  logic          nrst = 1'b0;
  logic          sync = 1'b0;
  logic [NB-1:0] data = '0;
  logic [NB-1:0] drv_sin;
  logic          drv_sclk_en, drv_lat, busy, err;
  logic [7:0]    col_sel;

  driver_controller #(.NB_DRIVERS(NB)) dut (
    .clk_33      (clk_33),
    .nrst        (nrst),
    .data        (data),
    .sync        (sync),
    .drv_sin     (drv_sin),
    .drv_sclk_en (drv_sclk_en),
    .drv_lat     (drv_lat),
    .col_sel     (col_sel),
    .busy        (busy),
    .err         (err)
  );

  always #15 clk_33 = ~clk_33;

  int total = 0;
  int bad = 0;

  int cyc, sync_at, sync_at2, abort_at, rst_at, mark;
  int idx, en_cnt, first_en, first_en_mark, lat_cnt, lat_bad, sin_bad;
  int err_cnt, err_cyc, win_lo, win_hi, lat_win, first_lat_mark;
  int busy_rise, busy_fall, busy_lo, busy_hi, busy_low;
  int lat_col[8];
  int col_cyc[$];
  logic [7:0] col_val[$];
  logic [7:0] prev_col;
  logic prev_busy;
  logic [NB-1:0] prev_data;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Expected latch for stream index i (planes counted down 8..0 within a column)
  function automatic logic lat_model(input int i);
    int wb;
    int plane;
    wb = i % 48;
    plane = 8 - ((i / 48) % 9);
    return (plane == 0) ? (wb >= 45) : (wb == 47);
  endfunction

  task automatic clear_stats();
    cyc = -1; sync_at = 0; sync_at2 = -100; abort_at = -100; rst_at = -100; mark = 0;
    idx = 0; en_cnt = 0; first_en = -1; first_en_mark = -1; lat_cnt = 0; lat_bad = 0;
    sin_bad = 0; err_cnt = 0; err_cyc = -1; win_lo = -1; win_hi = -2; lat_win = 0;
    first_lat_mark = -1; busy_rise = -1; busy_fall = -1; busy_lo = -1; busy_hi = -2;
    busy_low = 0;
    for (int i = 0; i < 8; i++) lat_col[i] = 0;
    col_cyc.delete();
    col_val.delete();
    prev_col = col_sel;
    prev_busy = busy;
  endtask

  task automatic sample();
    logic exp_lat;
    logic [NB-1:0] exp_sin;
    exp_lat = drv_sclk_en && lat_model(idx);
    exp_sin = drv_sclk_en ? prev_data : '0;
    if (drv_lat !== exp_lat) lat_bad++;
    if (drv_sin !== exp_sin) sin_bad++;
    if (drv_sclk_en) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
      if (cyc >= mark && first_en_mark < 0) first_en_mark = cyc;
    end
    if (drv_lat) begin
      lat_cnt++;
      lat_col[idx / COL_BITS]++;
      if (cyc >= win_lo && cyc <= win_hi) lat_win++;
      if (cyc >= mark && first_lat_mark < 0) first_lat_mark = cyc;
    end
    if (drv_sclk_en) idx = (idx + 1) % SLICE;
    if (busy && !prev_busy && busy_rise < 0) busy_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    if (!busy && cyc >= busy_lo && cyc <= busy_hi) busy_low++;
    prev_busy = busy;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (col_sel != prev_col) begin
      col_cyc.push_back(cyc);
      col_val.push_back(col_sel);
      prev_col = col_sel;
    end
  endtask

  // One clock: drive inputs for the new cycle, then sample mid-cycle
  task automatic tick();
    @(posedge clk_33);
    #1;
    cyc++;
    prev_data = data;
    data = (cyc % 2 == 0) ? PAT_A : PAT_B;
    sync = (cyc == sync_at) || (cyc == sync_at2);
    nrst = !(cyc == rst_at);
    @(negedge clk_33);
    sample();
    if (cyc == abort_at || cyc == rst_at) idx = 0;
  endtask

  initial begin
    logic [7:0] e;
    nrst = 1'b0;
    repeat (2) @(posedge clk_33);
    #1;
    nrst = 1'b1;
    @(negedge clk_33);
    check("rst_sin", drv_sin, 0);
    check("rst_sclk_en", drv_sclk_en, 0);
    check("rst_lat", drv_lat, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_col_sel", col_sel, 8'h01);

    // Nominal slice
    clear_stats();
    busy_lo = 1; busy_hi = 3535;
    repeat (3600) tick();
    check("nom_first_en", first_en, 80);
    check("nom_en_cnt", en_cnt, 3456);
    check("nom_busy_rise", busy_rise, 1);
    check("nom_busy_fall", busy_fall, 3536);
    check("nom_busy_low", busy_low, 0);
    check("nom_lat_cnt", lat_cnt, 88);
    for (int i = 0; i < 8; i++) check($sformatf("nom_lat_col%0d", i), lat_col[i], 11);
    check("nom_lat_pos", lat_bad, 0);
    check("nom_sin", sin_bad, 0);
    check("nom_err", err_cnt, 0);
    check("nom_col_steps", col_val.size(), 8);
    for (int i = 0; i < 8; i++) begin
      e = 8'(1) << ((i + 1) % 8);
      if (i < col_val.size()) check($sformatf("nom_col_val%0d", i), col_val[i], e);
      else check($sformatf("nom_col_val%0d", i), -1, e);
    end
    check("nom_col_first_cyc", (col_cyc.size() > 0) ? col_cyc[0] : -1, 512);
    check("nom_col_last_cyc", (col_cyc.size() == 8) ? col_cyc[7] : -1, 3536);
    check("nom_col_end", col_sel, 8'h01);

    // Early sync inside the stream
    clear_stats();
    sync_at2 = 1000; abort_at = 1000; mark = 1001;
    win_lo = 1001; win_hi = 1080; busy_lo = 1; busy_hi = 4535;
    repeat (4600) tick();
    check("early_err_cnt", err_cnt, 1);
    check("early_err_cyc", err_cyc, 1001);
    check("early_lat_window", lat_win, 0);
    check("early_first_en", first_en_mark, 1080);
    check("early_first_lat", first_lat_mark, 1127);
    check("early_en_cnt", en_cnt, 4377);
    check("early_busy_low", busy_low, 0);
    check("early_busy_fall", busy_fall, 4536);
    check("early_lat_pos", lat_bad, 0);
    check("early_sin", sin_bad, 0);
    check("early_col_end", col_sel, 8'h04);

    // Back-to-back sync on the final stream bit
    clear_stats();
    sync_at2 = 3534; mark = 3536; busy_lo = 1; busy_hi = 7069;
    repeat (7200) tick();
    check("b2b_err", err_cnt, 0);
    check("b2b_busy_low", busy_low, 0);
    check("b2b_first_en2", first_en_mark, 3614);
    check("b2b_en_cnt", en_cnt, 6912);
    check("b2b_busy_fall", busy_fall, 7070);
    check("b2b_lat_cnt", lat_cnt, 176);
    check("b2b_lat_pos", lat_bad, 0);
    check("b2b_sin", sin_bad, 0);
    check("b2b_col_steps", col_val.size(), 16);
    check("b2b_col_end", col_sel, 8'h04);

    // Reset pulse mid-stream, then a fresh slice
    clear_stats();
    rst_at = 500; sync_at2 = 600; mark = 601;
    repeat (502) tick();
    check("mrst_sin", drv_sin, 0);
    check("mrst_sclk_en", drv_sclk_en, 0);
    check("mrst_lat", drv_lat, 0);
    check("mrst_busy", busy, 0);
    check("mrst_err", err, 0);
    check("mrst_col_sel", col_sel, 8'h01);
    repeat (3700) tick();
    check("mrst_first_en", first_en_mark, 680);
    check("mrst_en_cnt", en_cnt, 3877);
    check("mrst_busy_fall", busy_fall, 4136);
    check("mrst_lat_pos", lat_bad, 0);
    check("mrst_sin", sin_bad, 0);
    check("mrst_err_cnt", err_cnt, 0);
    check("mrst_col_end", col_sel, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
